// File: rtl/chip_mode_seq_if.sv
// chip_mode_seq_if: mode-change request handshake between a requester and chip_mode_seq
interface chip_mode_seq_if #(parameter int MODE_W = 2);
  logic              mode_req_valid;
  logic              mode_req_ready;
  logic [MODE_W-1:0] mode_req_data;
  modport master(output mode_req_valid, mode_req_data, input mode_req_ready);
  modport slave(input mode_req_valid, mode_req_data, output mode_req_ready);
endinterface

// File: rtl/chip_mode_seq.sv
// chip_mode_seq: drains, switches and settles the CHIP mode while generating its bus-clock strobe
module chip_mode_seq #(
  parameter int MODE_W        = 2,
  parameter int DIV_W         = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               sysclk,
  input  logic               rst,
  chip_mode_seq_if.slave     req,
  input  logic [DIV_W-1:0]   div_ratio,
  input  logic               busy_in,
  output logic [MODE_W-1:0]  cmode,
  output logic               bclko,
  output logic               hold,
  output logic               mode_done
);
  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;
  state_t            state_q, state_d;
  logic [MODE_W-1:0] cmode_q, cmode_d, cap_q, cap_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, lat_q, lat_d;
  logic [7:0]        scnt_q, scnt_d;
  logic              init_q, bclko_q, bclko_d, hold_q, hold_d, done_q, done_d;
  logic              load, accept;
  assign req.mode_req_ready = (state_q == IDLE) && !rst;
  assign accept = req.mode_req_valid && req.mode_req_ready;
  assign load = init_q || bclko_q;
  always_comb begin
    state_d = state_q;
    cmode_d = cmode_q;
    cap_d   = cap_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (req.mode_req_data != cmode_q) begin
          cap_d   = req.mode_req_data;
          state_d = DRAIN;
        end else done_d = 1'b1;
      end
      DRAIN: if (!busy_in && bclko_q) begin
        state_d = SWITCH;
        cmode_d = cap_q;
      end
      SWITCH: begin
        state_d = SETTLE;
        scnt_d  = 8'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        scnt_d  = (scnt_q == 8'd0) ? 8'd0 : scnt_q - 8'd1;
        state_d = (scnt_q == 8'd0) ? IDLE : SETTLE;
        done_d  = scnt_q == 8'd0;
      end
      default: state_d = IDLE;
    endcase
    lat_d   = load ? div_ratio : lat_q;
    cnt_d   = (load || state_q == SWITCH) ? '0 : cnt_q + 1'b1;
    bclko_d = cnt_d == lat_d;
    hold_d  = state_d != IDLE;
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      cmode_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      scnt_q  <= '0;
      init_q  <= 1'b1;
      bclko_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmode_q <= cmode_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      scnt_q  <= scnt_d;
      init_q  <= 1'b0;
      bclko_q <= bclko_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end
  assign cmode     = cmode_q;
  assign bclko     = bclko_q;
  assign hold      = hold_q;
  assign mode_done = done_q;
endmodule

// File: doc/chip_mode_seq.md
CHIP_MODE_SEQ -- requirements
Module: chip_mode_seq

Interface
REQ-001 SHALL have parameter MODE_W, default 2, width of the chip mode word (cmode).
REQ-002 SHALL have parameter DIV_W, default 4, width of the bus-clock divide ratio.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, number of settle cycles after a mode switch; legal range is 1..255.
REQ-004 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on the rising edge of sysclk.
REQ-006 mode_req_valid  in  1  mode-change request is valid.
REQ-007 mode_req_ready  out  1  block accepts a request this cycle.
REQ-008 mode_req_data  in  MODE_W  requested mode.
REQ-009 div_ratio  in  DIV_W  bclko strobe period is div_ratio+1 sysclk cycles.
REQ-010 busy_in  in  1  downstream CHIP has a transaction in flight.
REQ-011 cmode  out  MODE_W  registered mode driven to the CHIP cmode input.
REQ-012 bclko  out  1  registered one-cycle bus-clock enable strobe driven to the CHIP bclko input.
REQ-013 hold  out  1  stalls the CHIP while a mode change is in progress.
REQ-014 mode_done  out  1  one-cycle pulse when a mode change completes.

Function
REQ-015 SHALL implement the FSM states IDLE, DRAIN, SWITCH and SETTLE.
REQ-016 SHALL drive mode_req_ready=1 only in IDLE with rst=0; a request is accepted on the edge where valid and ready are both 1.
REQ-017 SHALL, on an accepted request whose data differs from cmode, capture the data and enter DRAIN on the next cycle.
REQ-018 SHALL, on an accepted request whose data equals cmode, stay in IDLE and pulse mode_done on the next cycle; hold stays 0.
REQ-019 SHALL assert hold in DRAIN, SWITCH and SETTLE, and deassert it in IDLE.
REQ-020 SHALL leave DRAIN for SWITCH when busy_in=0 and bclko=1 in the same cycle; otherwise it stays in DRAIN indefinitely.
REQ-021 SWITCH SHALL last exactly 1 cycle: cmode takes the captured mode on the edge that enters SWITCH, and the divider counter clears to 0 on the edge that leaves SWITCH.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter, then return to IDLE.
REQ-023 SHALL pulse mode_done=1 in the first IDLE cycle after SETTLE; in that same cycle hold=0 and mode_req_ready=1.
REQ-024 Divider: counter SHALL run modulo (div_ratio_latched+1); bclko=1 in the cycle the counter equals div_ratio_latched.
REQ-025 Divider: div_ratio SHALL be latched at reset release and at each counter wrap; a mid-period change takes effect at the next wrap.
REQ-026 div_ratio=0 SHALL produce bclko=1 every cycle; div_ratio at its maximum (2^DIV_W-1) SHALL produce a period of 2^DIV_W cycles with no overflow.
REQ-027 SHALL keep the divider running in every state, including during hold.
REQ-028 SHALL ignore mode_req_valid outside IDLE; mode_req_data is not sampled there.
REQ-029 All outputs SHALL be registered, except mode_req_ready, which is a decode of state and rst.

Reset
REQ-030 While rst=1: state=IDLE, cmode=0, bclko=0, hold=0, mode_done=0, mode_req_ready=0, divider counter=0, settle counter=0.
REQ-031 rst asserted in any state SHALL abort the mode change in progress at the next edge; no mode_done is produced for the aborted request.
REQ-032 After rst falls: div_ratio is latched in the first cycle, and the first bclko occurs div_ratio+1 cycles later.

Verification
REQ-033 Divider: div_ratio=3, no requests, 20 cycles -> bclko=1 in every 4th cycle, cmode=0, hold=0 throughout.
REQ-034 Mode change: div_ratio=1, SETTLE_CYCLES=8, busy_in=0, request mode 2 -> hold rises next cycle; cmode=2 at the first DRAIN-cycle bclko +1; 8 settle cycles; mode_done pulses once with hold=0.
REQ-035 Busy drain: busy_in=1 for 10 cycles after acceptance -> cmode unchanged and hold=1 throughout; the switch occurs at the first cycle with bclko=1 and busy_in=0.
REQ-036 Same mode: cmode=2, request 2 -> mode_done pulses 1 cycle later; hold never asserts; cmode stays 2.
REQ-037 Reset mid-change: rst asserted during SETTLE -> next cycle cmode=0, hold=0, no mode_done; after rst release, ready=1 in the first cycle with rst=0.
REQ-038 Ratio change and back-pressure: div_ratio 5->0 mid-period -> the current period completes at 6 cycles, then bclko=1 every cycle; a second request held valid during SETTLE is accepted in the mode_done cycle.
